// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared constants and state encoding for the 4-bit divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Operand width and number of restoring iterations (one per quotient bit)
  localparam int OP_WIDTH   = 4;
  localparam int ITER_COUNT = 4;
  localparam int CNT_WIDTH  = 2;

  // Controller state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/subtractor_4bit.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_4bit
// Purpose  : Ripple-borrow subtractor, D = A - B - BIN, BOUT = borrow out.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       BIN,
  output logic [3:0] D,
  output logic       BOUT
);

  logic [4:0] w_borrow;

  assign w_borrow[0] = BIN;

  // One full-subtractor cell per bit, borrow rippling from LSB to MSB
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign D[i]            = A[i] ^ B[i] ^ w_borrow[i];
    assign w_borrow[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_borrow[i]);
  end

  assign BOUT = w_borrow[4];

endmodule
`default_nettype wire

// File: rtl/divider_4bit.sv
`default_nettype none
// ============================================================================
// Module   : divider_4bit
// Purpose  : Sequential 4-bit unsigned restoring divider, one quotient bit per
//            cycle, with a fast path for a zero divisor.
// Revision : 1.0 - initial release
// ============================================================================
module divider_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  import div_pkg::*;

  state_t                state_q, state_d;
  logic [OP_WIDTH:0]     p_q, p_d;          // partial remainder, one guard bit
  logic [OP_WIDTH-1:0]   q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [OP_WIDTH-1:0]   dvsr_q, dvsr_d;    // captured divisor
  logic [OP_WIDTH-1:0]   quot_q, quot_d;
  logic [OP_WIDTH-1:0]   rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [OP_WIDTH:0]     w_shift_p;
  logic [OP_WIDTH-1:0]   w_diff;
  logic                  w_bout;
  logic                  w_ok;
  logic [OP_WIDTH:0]     w_p_step;
  logic [OP_WIDTH-1:0]   w_q_step;
  logic                  w_last;

  // One restoring step: shift {P,Q} left, trial-subtract the divisor
  assign w_shift_p = {p_q[OP_WIDTH-1:0], q_q[OP_WIDTH-1]};

  subtractor_4bit u_sub (
    .A    (w_shift_p[OP_WIDTH-1:0]),
    .B    (dvsr_q),
    .BIN  (1'b0),
    .D    (w_diff),
    .BOUT (w_bout)
  );

  // Guard bit set means the shifted value already exceeds any 4-bit divisor;
  // in that case the true difference still fits in 4 bits, so D is exact.
  assign w_ok     = w_shift_p[OP_WIDTH] | ~w_bout;
  assign w_p_step = w_ok ? {1'b0, w_diff} : w_shift_p;
  assign w_q_step = {q_q[OP_WIDTH-2:0], w_ok};
  assign w_last   = (cnt_q == CNT_WIDTH'(ITER_COUNT - 1));

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dvsr_q  <= dvsr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: IDLE -> RUN (or straight to DONE on zero divisor) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on accepted start, iterate in RUN, publish results
  always_comb begin
    p_d    = p_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    dvsr_d = dvsr_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            quot_d = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
          end else begin
            p_d   = '0;
            q_d   = dividend;
            cnt_d = '0;
          end
        end
      end
      ST_RUN: begin
        p_d   = w_p_step;
        q_d   = w_q_step;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (w_last) begin
          quot_d = w_q_step;
          rem_d  = w_p_step[OP_WIDTH-1:0];
          dbz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: status decoded from state, results straight from their registers
  always_comb begin
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_4bit
// Purpose  : Scoreboard bench for divider_4bit with a plain-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  divider_4bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division, with the fixed zero-divisor convention
  function automatic res_t model(input int a, input int b);
    res_t res;
    if (b == 0) begin
      res.q = 4'hF;
      res.r = a[3:0];
      res.z = 1'b1;
    end else begin
      res.q = 4'(a / b);
      res.r = 4'(a % b);
      res.z = 1'b0;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("no_x_outputs", 32'($isunknown({busy, done, quotient, remainder, div_by_zero})), 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", exp_q.size(), 1);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.z);
        end
      end
    end
  end

  // Issue one division; optionally pulse a stray start (2/1) during RUN.
  // Returns in the IDLE cycle after done, so a following call is back-to-back.
  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input bit inject);
    res_t e;
    int   lat;
    int   waitc;
    e     = model(int'(a), int'(b));
    waitc = 0;
    while (busy && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(e);
    @(posedge clk); #1;            // start-sampling edge
    start    = 1'b0;
    dividend = 4'($urandom);       // operands must already be captured
    divisor  = 4'($urandom);
    lat = 0;
    while (!done && lat < 20) begin
      if (inject) begin
        start = (lat == 1);
        if (lat == 1) begin
          dividend = 4'd2;
          divisor  = 4'd1;
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    // Edges after the start-sampling edge until done is visible
    chk("done_latency", lat, (b == 4'd0) ? 0 : 4);
    chk("busy_with_done", busy, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
    chk("hold_quotient", quotient, e.q);
    chk("hold_remainder", remainder, e.r);
    chk("hold_dbz", div_by_zero, e.z);
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed scenarios
    do_div(4'd13, 4'd4, 1'b0);
    do_div(4'd15, 4'd1, 1'b0);
    do_div(4'd5,  4'd7, 1'b0);     // back-to-back with the previous result
    do_div(4'd9,  4'd0, 1'b0);
    do_div(4'd14, 4'd3, 1'b1);     // stray start during RUN must be ignored
    repeat (8) @(posedge clk);
    #1;

    // Reset in the second RUN cycle of 12/5 aborts with no done
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(4'(a), 4'(b), 1'b0);
      end
    end

    // Random pairs, some with stray starts
    repeat (40) begin
      do_div(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
